// File: rtl/serial_tx.sv
// Frame-based serial transmitter: START(0), WIDTH data bits LSB first, optional even parity, STOP(1).
// Define SERIAL_TX_PARITY_EN to insert the parity bit between the data bits and STOP.
module serial_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_INDEX = IW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [TW-1:0]    timer;
    logic [IW-1:0]    index;
    logic [WIDTH-1:0] payload;
    logic [IW-1:0]    index_next;
    logic             bit_end;

    assign index_next = index + 1'b1;
    assign bit_end    = (timer == '0);
    assign ready      = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            done    <= 1'b0;
            timer   <= '0;
            index   <= '0;
            payload <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        state   <= START;
                        tx      <= 1'b0;
                        timer   <= TIMER_LOAD;
                        index   <= '0;
                        payload <= data_in;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= payload[0];
                        timer <= TIMER_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= TIMER_LOAD;
                        if (index == LAST_INDEX) begin
`ifdef SERIAL_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^payload;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            index <= index_next;
                            tx    <= payload[index_next];
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                        timer <= TIMER_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                STOP: begin
                    // done is raised together with the move to IDLE so it lands in the first idle cycle
                    if (bit_end) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: table-driven frames checked cycle by cycle through a scoreboard.
// Follows SERIAL_TX_PARITY_EN so the expected frames match the build under test.
module tb_serial_tx;

    localparam int unsigned BC = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned FB  = 11;
    localparam int unsigned FB1 = 4;
`else
    localparam int unsigned FB  = 10;
    localparam int unsigned FB1 = 3;
`endif
    localparam int unsigned NB = FB * BC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid = 1'b0;
    logic       ready, tx, busy, done;

    logic [0:0] data1 = 1'b0;
    logic       valid1 = 1'b0;
    logic       ready1, tx1, busy1, done1;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;
    logic txq[$];
    int   done_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // transmission order, leftmost bit first
        logic       par;
    } vec_t;
    vec_t vecs[4];

    serial_tx #(.WIDTH(8), .BIT_CYCLES(BC)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy), .done(done)
    );

    serial_tx #(.WIDTH(1), .BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .data_in(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic exp_tx;
        logic exp_busy;
        int   dummy;
        if (mon_en) begin
            exp_busy = (txq.size() != 0);
            exp_tx   = exp_busy ? txq.pop_front() : 1'b1;
            check("tx", {31'd0, tx}, {31'd0, exp_tx});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("ready", {31'd0, ready}, {31'd0, !exp_busy});
            if (done_q.size() != 0 && done_q[0] == cyc) begin
                check("done_pulse", {31'd0, done}, 32'd1);
                dummy = done_q.pop_front();
            end else begin
                check("done_quiet", {31'd0, done}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers d until accepted, then queues the expected line values and done cycle.
    task automatic send(input logic [7:0] d, input logic [9:0] frame, input logic par,
                        output int acc_cyc);
        bit acc;
        int waited;
        acc = 1'b0;
        waited = 0;
        acc_cyc = -1;
        data_in = d;
        valid = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = ready;
            tick();
            waited++;
        end
        valid = 1'b0;
        data_in = ~d;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc_cyc = cyc;
            for (int i = 9; i >= 0; i--) begin
`ifdef SERIAL_TX_PARITY_EN
                if (i == 0) repeat (BC) txq.push_back(par);
`endif
                repeat (BC) txq.push_back(frame[i]);
            end
            done_q.push_back(cyc + NB);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((txq.size() != 0 || done_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        check("drain_timeout", {31'd0, (txq.size() != 0 || done_q.size() != 0)}, 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int a1, a2;
        logic [3:0] seq1;

        vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
        vecs[1] = '{8'h07, 10'b0111000001, 1'b1};
        vecs[2] = '{8'h80, 10'b0000000011, 1'b1};
        vecs[3] = '{8'h3C, 10'b0001111001, 1'b0};

        // Reset held two cycles, then idle with valid low
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();

        foreach (vecs[k]) begin
            send(vecs[k].data, vecs[k].frame, vecs[k].par, a1);
            drain();
        end

        // Back-to-back with valid held: second acceptance lands in the done cycle
        send(8'h3C, 10'b0001111001, 1'b0, a1);
        send(8'hC3, 10'b0110000111, 1'b0, a2);
        check("b2b_accept_cycle", a2, a1 + NB + 1);
        drain();

        // Reset 13 clocks into a frame aborts it without a done pulse
        send(8'hFF, 10'b0111111111, 1'b0, a1);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        txq.delete();
        done_q.delete();
        repeat (4) tick();
        send(8'h01, 10'b0100000001, 1'b1, a1);
        drain();

        // Single-bit payload, one clock per bit
`ifdef SERIAL_TX_PARITY_EN
        seq1 = 4'b0111;
`else
        seq1 = 4'b0011;
`endif
        data1 = 1'b1;
        valid1 = 1'b1;
        @(negedge clk);
        check("w1_ready", {31'd0, ready1}, 32'd1);
        tick();
        valid1 = 1'b0;
        data1 = 1'b0;
        for (int k = 0; k < int'(FB1); k++) begin
            @(negedge clk);
            check("w1_tx", {31'd0, tx1}, {31'd0, seq1[FB1-1-k]});
            check("w1_busy", {31'd0, busy1}, 32'd1);
            check("w1_done_quiet", {31'd0, done1}, 32'd0);
        end
        @(negedge clk);
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_ready_after", {31'd0, ready1}, 32'd1);
        check("w1_tx_idle", {31'd0, tx1}, 32'd1);
        @(negedge clk);
        check("w1_done_once", {31'd0, done1}, 32'd0);
        check("w1_busy_idle", {31'd0, busy1}, 32'd0);

        tick();
        check("txq_empty", txq.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
